// File: rtl/bus_slot_hub_pkg.sv
// Shared types and constants for the bus slot hub and its watchdog.
package bus_slot_hub_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDone
   } state_e;

   localparam logic [31:0] DefaultErrData = 32'hDEAD_BEEF;
   localparam int unsigned SlotIdxW       = 4;

   // The base must sit on a boundary covering all 16 possible slot windows.
   function automatic logic base_aligned(input logic [31:0] base, input int unsigned window_bits);
      logic [31:0] mask;
      mask = (32'd1 << (window_bits + SlotIdxW)) - 32'd1;
      return (base & mask) == 32'd0;
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter with enable/clear; pulses o_timeout on the enabled cycle
// where the count has reached TIMEOUT-1.
module bus_watchdog #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_clear,
   output logic o_timeout
);

   logic [7:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= 8'd0;
      end else if (i_clear) begin
         r_count <= 8'd0;
      end else if (i_en) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign o_timeout = i_en && (r_count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/bus_slot_hub.sv
// Memory-mapped hub: decodes an address window into slots with a watchdog.
// BUS_SLOT_HUB_ERR_COUNT_EN enables the saturating error counter.
module bus_slot_hub
   import bus_slot_hub_pkg::*;
#(
   parameter int unsigned       SLOTS       = 4,
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       WINDOW_BITS = 8,
   parameter logic [31:0]       BASE_ADDR   = 32'hFFFF_0000,
   parameter int unsigned       TIMEOUT     = 15,
   parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(DefaultErrData)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_read,
   input  logic                    i_write,
   input  logic [31:0]             i_address,
   input  logic [DATA_W-1:0]       i_wdata,
   input  logic [DATA_W/8-1:0]     i_byte_enable,
   output logic [DATA_W-1:0]       o_rdata,
   output logic                    o_ready,
   output logic                    o_bus_error,
   output logic [15:0]             o_err_count,
   output logic [SLOTS-1:0]        o_slot_sel,
   output logic                    o_slot_read,
   output logic                    o_slot_write,
   output logic [WINDOW_BITS-1:0]  o_slot_address,
   output logic [DATA_W-1:0]       o_slot_wdata,
   output logic [DATA_W/8-1:0]     o_slot_byte_enable,
   input  logic [SLOTS*DATA_W-1:0] i_slot_rdata,
   input  logic [SLOTS-1:0]        i_slot_ready
);

   localparam int unsigned TagLsb = WINDOW_BITS + SlotIdxW;
   // A misaligned base would alias windows, so such a build never decodes.
   localparam bit BaseOk = base_aligned(BASE_ADDR, WINDOW_BITS);

   state_e                r_state, w_state_d;
   logic                  r_pend, r_err_pend, r_is_read;
   logic                  r_ready, r_bus_error, r_slot_read, r_slot_write;
   logic [SLOTS-1:0]      r_sel;
   logic [WINDOW_BITS-1:0] r_offset;
   logic [DATA_W-1:0]     r_wdata, r_rdata, r_cap;
   logic [DATA_W/8-1:0]   r_be;

   logic                  w_req, w_in_range, w_idx_ok, w_sel_ready, w_timeout;
   logic                  w_go_wait, w_to_done, w_done_err, w_issue, w_wd_en, w_wd_clr;
   logic [SlotIdxW-1:0]   w_idx;
   logic [DATA_W-1:0]     w_slot_rdata;

   assign w_req       = i_read | i_write;
   assign w_in_range  = BaseOk && (i_address[31:TagLsb] == BASE_ADDR[31:TagLsb]);
   assign w_idx       = i_address[WINDOW_BITS +: SlotIdxW];
   assign w_idx_ok    = {1'b0, w_idx} < 5'(SLOTS);
   assign w_sel_ready = |(i_slot_ready & r_sel);

   always_comb begin
      w_slot_rdata = '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
         if (r_sel[i]) w_slot_rdata = i_slot_rdata[i*DATA_W +: DATA_W];
      end
   end

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (w_wd_en),
      .i_clear   (w_wd_clr),
      .o_timeout (w_timeout)
   );

   always_comb begin
      w_state_d  = r_state;
      w_go_wait  = 1'b0;
      w_to_done  = 1'b0;
      w_done_err = 1'b0;
      w_issue    = 1'b0;
      w_wd_en    = 1'b0;
      w_wd_clr   = 1'b1;
      unique case (r_state)
         StIdle: begin
            if (w_req && w_in_range) begin
               if (w_idx_ok && !(i_read && i_write)) begin
                  w_state_d = StWait;
                  w_go_wait = 1'b1;
               end else begin
                  w_state_d  = StDone;
                  w_to_done  = 1'b1;
                  w_done_err = 1'b1;
               end
            end
         end
         StWait: begin
            w_wd_en  = 1'b1;
            w_wd_clr = 1'b0;
            if (w_sel_ready) begin
               w_state_d = StDone;
               w_to_done = 1'b1;
            end else if (w_timeout) begin
               w_state_d  = StDone;
               w_to_done  = 1'b1;
               w_done_err = 1'b1;
            end
         end
         StDone: begin
            // First DONE cycle issues the response; then wait for the request to drop.
            w_issue = r_pend;
            if (!r_pend && !w_req) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_pend       <= 1'b0;
         r_err_pend   <= 1'b0;
         r_is_read    <= 1'b0;
         r_ready      <= 1'b0;
         r_bus_error  <= 1'b0;
         r_slot_read  <= 1'b0;
         r_slot_write <= 1'b0;
         r_sel        <= '0;
         r_offset     <= '0;
         r_wdata      <= '0;
         r_be         <= '0;
         r_rdata      <= '0;
         r_cap        <= '0;
      end else begin
         r_state     <= w_state_d;
         r_pend      <= w_to_done;
         r_ready     <= w_issue;
         r_bus_error <= w_issue & r_err_pend;
         if (w_to_done) r_err_pend <= w_done_err;
         if (r_state == StIdle && w_req && w_in_range) begin
            r_offset  <= i_address[WINDOW_BITS-1:0];
            r_wdata   <= i_wdata;
            r_be      <= i_byte_enable;
            r_is_read <= i_read;
         end
         if (w_go_wait) begin
            r_sel        <= SLOTS'(1) << w_idx;
            r_slot_read  <= i_read;
            r_slot_write <= i_write;
         end
         if (r_state == StWait && w_sel_ready) r_cap <= w_slot_rdata;
         if (w_issue) begin
            r_sel        <= '0;
            r_slot_read  <= 1'b0;
            r_slot_write <= 1'b0;
            if (r_is_read) r_rdata <= r_err_pend ? ERR_DATA : r_cap;
         end
      end
   end

`ifdef BUS_SLOT_HUB_ERR_COUNT_EN
   logic [15:0] r_err_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err_count <= 16'd0;
      end else if (w_issue && r_err_pend && (r_err_count != 16'hFFFF)) begin
         r_err_count <= r_err_count + 16'd1;
      end
   end

   assign o_err_count = r_err_count;
`else
   assign o_err_count = 16'd0;
`endif

   assign o_rdata            = r_rdata;
   assign o_ready            = r_ready;
   assign o_bus_error        = r_bus_error;
   assign o_slot_sel         = r_sel;
   assign o_slot_read        = r_slot_read;
   assign o_slot_write       = r_slot_write;
   assign o_slot_address     = r_offset;
   assign o_slot_wdata       = r_wdata;
   assign o_slot_byte_enable = r_be;

endmodule
